// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and the default operand width.
package seq_mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/seq_mult_fsm.sv
// Control FSM for seq_mult_core: sequences LOAD/CHECK/ADD/SHIFT/DONE.
// Every output is decoded from the state register alone (Moore).
module seq_mult_fsm
  import seq_mult_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic go,
  input  logic b_zero,
  input  logic b_lsb,
  output logic load,
  output logic add,
  output logic shift,
  output logic busy,
  output logic done
);

  state_t state_q, state_d;

  always_comb begin
    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_LOAD;
      S_LOAD:  state_d = S_CHECK;
      S_CHECK: begin
        if (b_zero)     state_d = S_DONE;
        else if (b_lsb) state_d = S_ADD;
        else            state_d = S_SHIFT;
      end
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: state_d = S_CHECK;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: clr is synchronous, so it is tested inside the clocked block, not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (clr) state_q <= S_IDLE;
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    else     state_q <= state_d;
  end

  assign load  = (state_q == S_LOAD);
  assign add   = (state_q == S_ADD);
  assign shift = (state_q == S_SHIFT);
  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);

endmodule

// File: rtl/seq_mult_core.sv
// Sequential shift-and-add multiplier datapath around seq_mult_fsm.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands (sign-magnitude internally).
module seq_mult_core
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               go,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic               load, add, shift, accept;
  logic [WIDTH-1:0]   a_cap_q, a_cap_d, b_cap_q, b_cap_d;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] a_reg_q, a_reg_d, acc_q, acc_d;
  logic [WIDTH-1:0]   b_reg_q, b_reg_d;

  seq_mult_fsm u_fsm (
    .clk    (clk),
    .clr    (clr),
    .go     (go),
    .b_zero (b_reg_q == '0),
    .b_lsb  (b_reg_q[0]),
    .load   (load),
    .add    (add),
    .shift  (shift),
    .busy   (busy),
    .done   (done)
  );

  // Operands are frozen on the accepting edge so later changes on a/b are ignored.
  assign accept = go && !busy;

`ifdef SEQ_MULT_SIGNED_EN
  logic sign_q, sign_d;

  // Negating the most negative value wraps to 2^(WIDTH-1), its correct unsigned magnitude.
  assign a_mag   = a_cap_q[WIDTH-1] ? -a_cap_q : a_cap_q;
  assign b_mag   = b_cap_q[WIDTH-1] ? -b_cap_q : b_cap_q;
  assign sign_d  = load ? (a_cap_q[WIDTH-1] ^ b_cap_q[WIDTH-1]) : sign_q;
  assign product = sign_q ? -acc_q : acc_q;

  always_ff @(posedge clk) begin
    if (clr) sign_q <= 1'b0;
    else     sign_q <= sign_d;
  end
`else
  assign a_mag   = a_cap_q;
  assign b_mag   = b_cap_q;
  assign product = acc_q;
`endif

  always_comb begin
    a_cap_d = a_cap_q;
    b_cap_d = b_cap_q;
    a_reg_d = a_reg_q;
    b_reg_d = b_reg_q;
    acc_d   = acc_q;
    if (accept) begin
      a_cap_d = a;
      b_cap_d = b;
    end
    if (load) begin
      acc_d   = '0;
      a_reg_d = {{WIDTH{1'b0}}, a_mag};
      b_reg_d = b_mag;
    end
    if (add) acc_d = acc_q + a_reg_q;
    if (shift) begin
      a_reg_d = a_reg_q << 1;
      b_reg_d = b_reg_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      a_cap_q <= '0;
      b_cap_q <= '0;
      a_reg_q <= '0;
      b_reg_q <= '0;
      acc_q   <= '0;
    end else begin
      a_cap_q <= a_cap_d;
      b_cap_q <= b_cap_d;
      a_reg_q <= a_reg_d;
      b_reg_q <= b_reg_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_seq_mult_core.sv
// Self-checking bench for seq_mult_core: directed cases plus randomized operands
// compared with an arithmetic reference model (honours SEQ_MULT_SIGNED_EN).
module tb_seq_mult_core;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           clr, go;
  logic [W-1:0]   a, b;
  logic           busy, done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;

  seq_mult_core #(.WIDTH(W)) dut (
    .clk     (clk),
    .clr     (clr),
    .go      (go),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int op_value(input logic [W-1:0] v);
`ifdef SEQ_MULT_SIGNED_EN
    return int'($signed(v));
`else
    return int'(v);
`endif
  endfunction

  function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] av, input logic [W-1:0] bv);
    longint p;
    p = longint'(op_value(av)) * longint'(op_value(bv));
    return p[2*W-1:0];
  endfunction

  // Cycles from the accepting edge to DONE: 3 + 2*(bit length of |b|) + popcount(|b|).
  function automatic int ref_cycles(input logic [W-1:0] bv);
    int m, k;
    m = op_value(bv);
    if (m < 0) m = -m;
    k = 0;
    while ((m >> k) != 0) k++;
    return 3 + 2 * k + $countones(m);
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the IDLE cycle after DONE.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit keep_go, input bit toggle, input string tag);
    logic [2*W-1:0] exp_p;
    logic [31:0]    r;
    int             exp_c, got_c;
    bit             busy_ok;
    exp_p   = ref_product(av, bv);
    exp_c   = ref_cycles(bv);
    got_c   = -1;
    busy_ok = 1'b1;
    a  = av;
    b  = bv;
    go = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (!keep_go) go = 1'b0;
      if (toggle) begin
        r = $urandom;
        a = r[7:0];
        b = r[15:8];
      end
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        got_c = c;
        break;
      end
    end
    check({tag, " done_cycle"}, got_c, exp_c);
    check({tag, " busy_span"}, 32'(busy_ok), 1);
    check({tag, " product"}, 32'(product), 32'(exp_p));
    @(negedge clk);
    check({tag, " idle_flags"}, 32'({busy, done}), 0);
    check({tag, " product_hold"}, 32'(product), 32'(exp_p));
  endtask

  initial begin
    logic [31:0] r;
    clr = 1'b1;
    go  = 1'b0;
    a   = '0;
    b   = '0;
    repeat (3) @(negedge clk);
    check("reset flags", 32'({busy, done}), 0);
    check("reset product", 32'(product), 0);

    // clr and go on the same edge: clr wins, nothing starts.
    go = 1'b1;
    a  = 8'd5;
    b  = 8'd3;
    @(negedge clk);
    check("clr_over_go busy", 32'(busy), 0);
    clr = 1'b0;
    go  = 1'b0;
    @(negedge clk);
    check("after_clr idle", 32'(busy), 0);

    run_op(8'd5,   8'd3,   1'b0, 1'b0, "a5_b3");
    run_op(8'd200, 8'd0,   1'b0, 1'b0, "b_zero");
    run_op(8'd0,   8'd255, 1'b0, 1'b0, "a_zero");
    run_op(8'd255, 8'd255, 1'b1, 1'b0, "ff_hold_go");
    run_op(8'd255, 8'd255, 1'b1, 1'b0, "ff_back2back");
    run_op(8'd12,  8'd34,  1'b0, 1'b0, "b2b_tail");
`ifndef SEQ_MULT_SIGNED_EN
    check("ff_const", 32'(product), 32'd408);
`endif

    // Reset during the third ADD of 7*7 (cycle 9 after the accept edge).
    a  = 8'd7;
    b  = 8'd7;
    go = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      go = 1'b0;
    end
    check("mid_op busy", 32'(busy), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("mid_clr flags", 32'({busy, done}), 0);
    check("mid_clr product", 32'(product), 0);
    run_op(8'd7, 8'd7, 1'b0, 1'b0, "after_mid_clr");
    check("seven_sq const", 32'(product), 32'd49);

`ifdef SEQ_MULT_SIGNED_EN
    run_op(8'hFD, 8'd5, 1'b0, 1'b0, "neg3_x5");
    check("neg3_x5 const", 32'(product), 32'h0000FFF1);
    run_op(8'h80, 8'h80, 1'b0, 1'b0, "min_x_min");
    check("min_x_min const", 32'(product), 32'd16384);
`endif

    for (int i = 0; i < 20; i++) begin
      r = $urandom;
      run_op(r[7:0], r[15:8], 1'b0, 1'b1, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_mult_core.md
SEQ_MULT_CORE -- requirements
Module: seq_mult_core

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: clr  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: go  input  1  start request, sampled only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  multiplicand, captured on the edge that accepts go.
REQ-006 SHALL have port: b  input  WIDTH  multiplier, captured on the edge that accepts go.
REQ-007 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port: done  output  1  single-cycle pulse, high only in DONE.
REQ-009 SHALL have port: product  output  2*WIDTH  result, valid from DONE until the next LOAD.

Function
REQ-010 SHALL implement states IDLE, LOAD, CHECK, ADD, SHIFT, DONE, all outputs Moore-decoded.
REQ-011 SHALL transition IDLE->LOAD when go=1, else remain in IDLE.
REQ-012 SHALL in LOAD clear the accumulator, load A register (2*WIDTH, zero-extended a) and B register (WIDTH, b); LOAD->CHECK.
REQ-013 SHALL in CHECK go to DONE if B register == 0, else to ADD if B[0]=1, else to SHIFT.
REQ-014 SHALL in ADD set accumulator <= accumulator + A register, modulo 2^(2*WIDTH); ADD->SHIFT.
REQ-015 SHALL in SHIFT shift A register left by 1 (zero fill) and B register right by 1 (zero fill); SHIFT->CHECK.
REQ-016 SHALL make DONE->IDLE unconditionally; done=1 for exactly that one cycle.
REQ-017 SHALL place DONE in cycle 3 + 2*k + n after the go-accepting edge (k = index of highest set bit of b plus 1, 0 if b=0; n = popcount of b).
REQ-018 SHALL ignore go while busy=1; a and b changes while busy SHALL have no effect.
REQ-019 SHALL accept go asserted in the IDLE cycle immediately after DONE (back-to-back operation, no dead cycle).
REQ-020 SHALL hold product stable from DONE through IDLE until the next LOAD clears it.
REQ-021 SHALL drive product from the accumulator register; no combinational path from a, b or go to any output.

Reset
REQ-022 SHALL on clr=1 at a rising edge force IDLE and clear accumulator, A, B and sign registers, regardless of state.
REQ-023 SHALL produce busy=0, done=0, product=0 in the cycle after reset, including reset mid-operation.
REQ-024 SHALL give clr priority over go on the same edge.

Configuration
REQ-025 SHALL, with macro SEQ_MULT_SIGNED_EN defined, treat a and b as two's complement: LOAD captures magnitudes |a|, |b| (unsigned, WIDTH bits) plus sign = a[MSB] XOR b[MSB], and DONE-time product = sign ? -accumulator : accumulator (2*WIDTH two's complement).
REQ-026 SHALL, with SEQ_MULT_SIGNED_EN defined, handle the most negative operand: -2^(WIDTH-1) has magnitude 2^(WIDTH-1) in WIDTH unsigned bits; REQ-017 cycle count uses |b|.
REQ-027 SHALL, without SEQ_MULT_SIGNED_EN, perform unsigned multiplication only and contain no sign register or negation logic.

Structure
REQ-028 SHALL place the state encoding constants (3-bit: IDLE=0, LOAD=1, CHECK=2, ADD=3, SHIFT=4, DONE=5) and the default WIDTH in shared package seq_mult_pkg.
REQ-029 SHALL split the FSM into sub-module seq_mult_fsm (inputs go, b_zero, b_lsb; outputs load, add, shift, busy, done); the datapath stays in seq_mult_core.
REQ-030 SHALL decode unused state encodings to IDLE on the next edge.

Verification
REQ-031 SHALL cover: WIDTH=8, a=5, b=3, go pulse -> done exactly 9 cycles after the accept edge, product=15, busy high for 9 cycles.
REQ-032 SHALL cover: a=200, b=0 -> done in cycle 3, product=0; then a=0, b=255 -> product=0, done in cycle 27.
REQ-033 SHALL cover: a=255, b=255 unsigned -> product=65025; go held high throughout -> a second operation starts in the IDLE cycle after DONE.
REQ-034 SHALL cover: clr asserted during the third ADD of a=7, b=7 -> next cycle busy=0, done=0, product=0, state IDLE; a later go with a=7, b=7 yields 49.
REQ-035 SHALL cover with SEQ_MULT_SIGNED_EN: a=-3, b=5 -> product=-15 (16'hFFF1); a=-128, b=-128 -> product=16384.
REQ-036 SHALL cover: a and b toggled randomly while busy -> product reflects only the values captured at accept.
